// File: rtl/bc_pkg.sv
// Shared types, constants and the per-step control table
// for the bc_scheduler polynomial datapath controller.
package bc_pkg;

  localparam logic [4:0] STEP_LAST    = 5'd19;
  localparam logic [4:0] STEP_CAPTURE = 5'd20;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    RESP
  } state_t;

  typedef struct packed {
    logic       LX;
    logic       LS;
    logic       LH;
    logic       Hula;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
  } ctrl_word_t;

  // Step 1 is the LOAD cycle; step 20 (capture) and anything outside 1..19 is idle.
  function automatic ctrl_word_t step_ctrl(input logic [4:0] step);
    ctrl_word_t c;
    c = '0;
    case (step)
      5'd1:  c.LX = 1'b1;
      5'd2:  c.M1 = 2'd1;
      5'd3:  begin c.M1 = 2'd1; c.Hula = 1'b1; end
      5'd4:  begin c.M1 = 2'd1; c.Hula = 1'b1; c.LH = 1'b1; end
      5'd5:  c.M0 = 2'd1;
      5'd6:  begin c.M0 = 2'd1; c.M2 = 2'd3; end
      5'd7:  begin c.M0 = 2'd1; c.M2 = 2'd3; c.Hula = 1'b1; end
      5'd8:  begin c.M0 = 2'd1; c.M2 = 2'd3; c.Hula = 1'b1; c.LH = 1'b1; end
      5'd9:  c.M0 = 2'd2;
      5'd10: c.M0 = 2'd2;
      5'd11: begin c.M0 = 2'd2; c.Hula = 1'b1; end
      5'd12: begin c.M0 = 2'd2; c.Hula = 1'b1; c.LS = 1'b1; end
      5'd13: begin c.M1 = 2'd2; c.M2 = 2'd3; end
      5'd14: begin c.M1 = 2'd2; c.M2 = 2'd3; end
      5'd15: begin c.M1 = 2'd2; c.M2 = 2'd3; c.LH = 1'b1; end
      5'd16: c.M0 = 2'd3;
      5'd17: begin c.M0 = 2'd3; c.M2 = 2'd3; end
      5'd18: begin c.M0 = 2'd3; c.M2 = 2'd3; end
      5'd19: begin c.M0 = 2'd3; c.M2 = 2'd3; c.LS = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bc_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer is held by the caller and
// only advances when both requesters contend for a grant.
module bc_rr_arbiter (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic       grant_valid,
  output logic       grant_id,
  output logic       ptr_next
);

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    ptr_next    = ptr;
    if (en) begin
      case (req)
        2'b01: begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_id    = ptr;
          ptr_next    = ~ptr;
        end
        default: grant_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/bc_scheduler.sv
// Shares the polynomial datapath between two requesters: grants a job, plays
// the 20-step control sequence and returns the captured S value.
module bc_scheduler
  import bc_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_x,
  output logic [NREQ-1:0]   req_ack,
  output logic              busy,
  output logic [W-1:0]      x_out,
  input  logic [W-1:0]      s_in,
  output logic              LX,
  output logic              LS,
  output logic              LH,
  output logic              Hula,
  output logic [1:0]        M0,
  output logic [1:0]        M1,
  output logic [1:0]        M2,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_data,
  input  logic              rsp_ready
);

  state_t            state_q, state_d;
  logic [4:0]        step_q, step_d;
  logic              ptr_q, ptr_d;
  ctrl_word_t        ctrl_q, ctrl_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [W-1:0]      x_q, x_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [W-1:0]      rsp_data_q, rsp_data_d;

  logic handshake;
  logic arb_en;
  logic grant_valid;
  logic grant_id;
  logic arb_ptr_next;

  // The handshake edge also arbitrates, so back-to-back jobs run 21 cycles apart.
  assign handshake = (state_q == RESP) && rsp_ready;
  assign arb_en    = (state_q == IDLE) || handshake;

  bc_rr_arbiter u_arb (
    .req         (req),
    .ptr         (ptr_q),
    .en          (arb_en),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ptr_next    (arb_ptr_next)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ptr_d       = arb_ptr_next;
    ack_d       = '0;
    x_d         = x_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: state_d = IDLE;
      LOAD: begin
        state_d = RUN;
        step_d  = step_q + 5'd1;
      end
      RUN: begin
        step_d = step_q + 5'd1;
        if (step_q == STEP_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = s_in;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_valid) begin
      state_d         = LOAD;
      step_d          = 5'd1;
      ack_d[grant_id] = 1'b1;
      x_d             = grant_id ? op_x[W +: W] : op_x[0 +: W];
      rsp_id_d        = grant_id;
    end

    busy_d = (state_d != IDLE);
    ctrl_d = ((state_d == LOAD) || (state_d == RUN)) ? step_ctrl(step_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      ptr_q       <= 1'b0;
      ctrl_q      <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      x_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      ptr_q       <= ptr_d;
      ctrl_q      <= ctrl_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ack   = ack_q;
  assign busy      = busy_q;
  assign x_out     = x_q;
  assign LX        = ctrl_q.LX;
  assign LS        = ctrl_q.LS;
  assign LH        = ctrl_q.LH;
  assign Hula      = ctrl_q.Hula;
  assign M0        = ctrl_q.M0;
  assign M1        = ctrl_q.M1;
  assign M2        = ctrl_q.M2;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bc_scheduler.sv
// Scoreboard bench for bc_scheduler: stimulus pushes expected responses,
// a negedge monitor pops them on every response handshake.
module tb_bc_scheduler;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req;
  logic [2*W-1:0] op_x;
  logic [1:0]     req_ack;
  logic           busy;
  logic [W-1:0]   x_out;
  logic [W-1:0]   s_in;
  logic           LX, LS, LH, Hula;
  logic [1:0]     M0, M1, M2;
  logic           rsp_valid;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;
  logic [9:0]     ctrl_bus;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_e;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  bc_scheduler #(.W(W), .NREQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_x      (op_x),
    .req_ack   (req_ack),
    .busy      (busy),
    .x_out     (x_out),
    .s_in      (s_in),
    .LX        (LX),
    .LS        (LS),
    .LH        (LH),
    .Hula      (Hula),
    .M0        (M0),
    .M1        (M1),
    .M2        (M2),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  assign ctrl_bus = {LX, LS, LH, Hula, M0, M1, M2};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // s_in carries the cycle number, so the captured value pins down the capture cycle.
  initial begin
    s_in = '0;
    forever begin
      @(posedge clk);
      #1;
      s_in = 16'hA000 + 16'(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [9:0] cw(input bit lx, input bit ls, input bit lh, input bit hu,
                                    input logic [1:0] m0, input logic [1:0] m1,
                                    input logic [1:0] m2);
    return {lx, ls, lh, hu, m0, m1, m2};
  endfunction

  function automatic logic [9:0] exp_ctrl(input int s);
    case (s)
      1:  return cw(1, 0, 0, 0, 2'd0, 2'd0, 2'd0);
      2:  return cw(0, 0, 0, 0, 2'd0, 2'd1, 2'd0);
      3:  return cw(0, 0, 0, 1, 2'd0, 2'd1, 2'd0);
      4:  return cw(0, 0, 1, 1, 2'd0, 2'd1, 2'd0);
      5:  return cw(0, 0, 0, 0, 2'd1, 2'd0, 2'd0);
      6:  return cw(0, 0, 0, 0, 2'd1, 2'd0, 2'd3);
      7:  return cw(0, 0, 0, 1, 2'd1, 2'd0, 2'd3);
      8:  return cw(0, 0, 1, 1, 2'd1, 2'd0, 2'd3);
      9:  return cw(0, 0, 0, 0, 2'd2, 2'd0, 2'd0);
      10: return cw(0, 0, 0, 0, 2'd2, 2'd0, 2'd0);
      11: return cw(0, 0, 0, 1, 2'd2, 2'd0, 2'd0);
      12: return cw(0, 1, 0, 1, 2'd2, 2'd0, 2'd0);
      13: return cw(0, 0, 0, 0, 2'd0, 2'd2, 2'd3);
      14: return cw(0, 0, 0, 0, 2'd0, 2'd2, 2'd3);
      15: return cw(0, 0, 1, 0, 2'd0, 2'd2, 2'd3);
      16: return cw(0, 0, 0, 0, 2'd3, 2'd0, 2'd0);
      17: return cw(0, 0, 0, 0, 2'd3, 2'd0, 2'd3);
      18: return cw(0, 0, 0, 0, 2'd3, 2'd0, 2'd3);
      19: return cw(0, 1, 0, 0, 2'd3, 2'd0, 2'd3);
      default: return 10'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cyc);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [2*W-1:0] x, input logic rdy);
    req       = r;
    op_x      = x;
    rsp_ready = rdy;
  endtask

  task automatic pushExpected(input logic id, input int ack_cyc);
    exp_t e;
    e.id   = id;
    e.data = 16'hA000 + 16'(ack_cyc + 19);
    exp_q.push_back(e);
  endtask

  task automatic waitAck(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      nextCycle();
      if (req_ack != 2'b00) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput("ack_timeout", 32'(req_ack), 32'h1);
  endtask

  task automatic waitIdle(input int bound);
    int done;
    done = 0;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      nextCycle();
    end
    if (done == 0) checkOutput("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_ctrl"}, 32'({req_ack, busy, ctrl_bus, rsp_valid, rsp_id}), 32'h0);
    checkOutput({name, "_x"}, 32'(x_out), 32'h0);
    checkOutput({name, "_data"}, 32'(rsp_data), 32'h0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2'b00, '0, 1'b0);
    repeat (3) nextCycle();
    reset = 1'b0;
  endtask

  // Response monitor: every handshake must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(exp_q.size()), 32'h1);
      end else begin
        exp_e = exp_q.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(exp_e.id));
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp_e.data));
      end
    end
  end

  initial begin
    int a;
    int prev;
    logic g;

    reset = 1'b1;
    applyStimulus(2'b00, '0, 1'b0);
    repeat (3) nextCycle();
    checkAllZero("reset");
    reset = 1'b0;

    // Single job, full control sequence and latency
    applyStimulus(2'b01, {16'h0000, 16'h0005}, 1'b1);
    waitAck(5, a);
    applyStimulus(2'b00, {16'h0000, 16'h0005}, 1'b1);
    checkOutput("t1_ack", 32'(req_ack), 32'h1);
    checkOutput("t1_x", 32'(x_out), 32'h5);
    checkOutput("t1_busy", 32'(busy), 32'h1);
    checkOutput("t1_step1", 32'(ctrl_bus), 32'(exp_ctrl(1)));
    pushExpected(1'b0, a);
    for (int s = 2; s <= 20; s++) begin
      nextCycle();
      checkOutput($sformatf("t1_step%0d", s), 32'(ctrl_bus), 32'(exp_ctrl(s)));
      checkOutput("t1_valid_early", 32'(rsp_valid), 32'h0);
    end
    nextCycle();
    checkOutput("t1_latency", 32'(rsp_valid), 32'h1);
    nextCycle();
    checkOutput("t1_valid_drop", 32'(rsp_valid), 32'h0);
    checkOutput("t1_busy_drop", 32'(busy), 32'h0);

    // Contention: grants alternate 0,1,0,1 every 21 cycles
    doReset();
    applyStimulus(2'b11, {16'h0022, 16'h0011}, 1'b1);
    prev = 0;
    for (int j = 0; j < 4; j++) begin
      waitAck(30, a);
      g = j[0];
      checkOutput("t2_ack", 32'(req_ack), g ? 32'h2 : 32'h1);
      checkOutput("t2_x", 32'(x_out), g ? 32'h22 : 32'h11);
      if (j > 0) checkOutput("t2_spacing", 32'(a - prev), 32'd21);
      pushExpected(g, a);
      prev = a;
    end
    applyStimulus(2'b00, {16'h0022, 16'h0011}, 1'b1);
    waitIdle(30);

    // Back-pressure: response held while rsp_ready is low
    doReset();
    applyStimulus(2'b01, {16'h0000, 16'h0033}, 1'b0);
    waitAck(5, a);
    applyStimulus(2'b10, {16'h0099, 16'h0033}, 1'b0);
    pushExpected(1'b0, a);
    repeat (20) nextCycle();
    for (int k = 0; k < 10; k++) begin
      checkOutput("t3_valid_hold", 32'(rsp_valid), 32'h1);
      checkOutput("t3_data_hold", 32'(rsp_data), 32'(16'hA000 + 16'(a + 19)));
      checkOutput("t3_id_hold", 32'(rsp_id), 32'h0);
      checkOutput("t3_no_ack", 32'(req_ack), 32'h0);
      checkOutput("t3_ctrl_zero", 32'(ctrl_bus), 32'h0);
      nextCycle();
    end
    applyStimulus(2'b00, {16'h0099, 16'h0033}, 1'b1);
    nextCycle();
    checkOutput("t3_valid_release", 32'(rsp_valid), 32'h0);
    checkOutput("t3_idle", 32'(busy), 32'h0);

    // Operand changes after ack must not reach x_out
    doReset();
    applyStimulus(2'b01, {16'h0000, 16'h0044}, 1'b1);
    waitAck(5, a);
    applyStimulus(2'b00, {16'hFFFF, 16'hFFFF}, 1'b1);
    pushExpected(1'b0, a);
    for (int s = 2; s <= 20; s++) begin
      nextCycle();
      checkOutput("t4_x_stable", 32'(x_out), 32'h44);
    end
    waitIdle(5);

    // Reset mid-job aborts it; pointer restarts at requester 0
    doReset();
    applyStimulus(2'b01, {16'h0000, 16'h0055}, 1'b1);
    waitAck(5, a);
    applyStimulus(2'b00, {16'h0000, 16'h0055}, 1'b1);
    pushExpected(1'b0, a);
    repeat (8) nextCycle();
    checkOutput("t5_step9", 32'(ctrl_bus), 32'(exp_ctrl(9)));
    reset = 1'b1;
    nextCycle();
    exp_q.delete();
    checkAllZero("t5_abort");
    reset = 1'b0;
    repeat (25) nextCycle();
    checkOutput("t5_no_rsp", 32'(rsp_valid), 32'h0);
    checkOutput("t5_idle", 32'(busy), 32'h0);
    applyStimulus(2'b10, {16'h0077, 16'h0000}, 1'b1);
    waitAck(5, a);
    applyStimulus(2'b00, {16'h0077, 16'h0000}, 1'b1);
    checkOutput("t5_ack", 32'(req_ack), 32'h2);
    checkOutput("t5_x", 32'(x_out), 32'h77);
    pushExpected(1'b1, a);
    waitIdle(30);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
